// File: rtl/avalon_mem_pkg.sv
// Shared types and constants for the
// fetch/data Avalon-MM master arbiter.
package avalon_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic {
    OWN_F = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  localparam logic [3:0] BE_WORD = 4'hF;
  localparam int READ_LATENCY = 1;

endpackage

// File: rtl/avalon_mem_arbiter.sv
// Shares one Avalon-MM master between fetch
// (read-only) and data (read/write) requesters.
module avalon_mem_arbiter
  import avalon_mem_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        active,
  input  logic        f_req,
  input  logic [31:0] f_addr,
  output logic        f_ack,
  output logic [31:0] f_rdata,
  output logic        f_stall,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [3:0]  d_byte_en,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_stall,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  input  logic        waitrequest,
  input  logic [31:0] readdata
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] CNT_MAX =
    CW'(STARVE_LIMIT);

  state_e        state_q, state_d;
  owner_e        owner_q, owner_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   address_q, address_d;
  logic          read_q, read_d;
  logic          write_q, write_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          f_ack_q, f_ack_d;
  logic          d_ack_q, d_ack_d;
  logic [31:0]   f_rdata_q, f_rdata_d;
  logic [31:0]   d_rdata_q, d_rdata_d;
  logic          take_f;

  // Low address bits never reach the bus.
  logic unused_addr_bits;
  assign unused_addr_bits =
    ^{f_addr[1:0], d_addr[1:0]};

  // Fetch wins only when data is absent or
  // fetch has waited through STARVE_LIMIT grants.
  assign take_f = f_req &
    (~d_req | (cnt_q == CNT_MAX));

  // Next-state, command latch and ack generation.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    address_d = address_q;
    read_d    = read_q;
    write_d   = write_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    f_ack_d   = 1'b0;
    d_ack_d   = 1'b0;
    f_rdata_d = f_rdata_q;
    d_rdata_d = d_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (!f_req) cnt_d = '0;
        if (active && (f_req || d_req)) begin
          state_d = CMD;
          if (take_f) begin
            owner_d   = OWN_F;
            cnt_d     = '0;
            address_d = {f_addr[31:2], 2'b00};
            read_d    = 1'b1;
            write_d   = 1'b0;
            be_d      = BE_WORD;
          end else begin
            owner_d   = OWN_D;
            if (f_req && cnt_q != CNT_MAX)
              cnt_d = cnt_q + CW'(1);
            address_d = {d_addr[31:2], 2'b00};
            read_d    = ~d_we;
            write_d   = d_we;
            be_d      = d_byte_en;
            wdata_d   = d_wdata;
          end
        end
      end
      CMD: begin
        if (!waitrequest) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          if (write_q) begin
            state_d = IDLE;
            d_ack_d = 1'b1;
          end else begin
            state_d = RESP;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
        if (owner_q == OWN_F) begin
          f_ack_d   = 1'b1;
          f_rdata_d = readdata;
        end else begin
          d_ack_d   = 1'b1;
          d_rdata_d = readdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset abandons any command.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      owner_q   <= OWN_F;
      cnt_q     <= '0;
      address_q <= '0;
      read_q    <= 1'b0;
      write_q   <= 1'b0;
      be_q      <= '0;
      wdata_q   <= '0;
      f_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      f_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      address_q <= address_d;
      read_q    <= read_d;
      write_q   <= write_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      f_ack_q   <= f_ack_d;
      d_ack_q   <= d_ack_d;
      f_rdata_q <= f_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign address    = address_q;
  assign read       = read_q;
  assign write      = write_q;
  assign byteenable = be_q;
  assign writedata  = wdata_q;
  assign f_ack      = f_ack_q;
  assign d_ack      = d_ack_q;
  assign f_rdata    = f_rdata_q;
  assign d_rdata    = d_rdata_q;
  assign f_stall    = f_req & ~f_ack_q;
  assign d_stall    = d_req & ~d_ack_q;

endmodule

// File: tb/tb_avalon_mem_arbiter.sv
// Self-checking bench: vector table, corner
// sequences, random traffic vs reference model.
module tb_avalon_mem_arbiter;

  localparam int LIMIT = 4;

  logic        clk, reset, active;
  logic        f_req, f_ack, f_stall;
  logic [31:0] f_addr, f_rdata;
  logic        d_req, d_we, d_ack, d_stall;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_byte_en;
  logic [31:0] address, writedata, readdata;
  logic        read, write, waitrequest;
  logic [3:0]  byteenable;

  avalon_mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset), .active(active),
    .f_req(f_req), .f_addr(f_addr),
    .f_ack(f_ack), .f_rdata(f_rdata),
    .f_stall(f_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
    .d_byte_en(d_byte_en), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .d_stall(d_stall),
    .address(address), .read(read), .write(write),
    .byteenable(byteenable),
    .writedata(writedata),
    .waitrequest(waitrequest),
    .readdata(readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [31:0] bus_mem [64];
  logic [31:0] ref_mem [64];

  bit new_cmd, prev_strobe, wait_rand;
  int wait_fixed, wait_left;
  bit w_last;
  bit [1:0] r_hist;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // One clock: slave model acts on the handshake
  // seen just before the edge.
  task automatic cyc();
    logic acc_r, acc_w;
    logic [31:0] a, wd;
    logic [3:0] be;
    acc_r = read && !waitrequest;
    acc_w = write && !waitrequest;
    a = address; wd = writedata; be = byteenable;
    @(posedge clk); #1;
    if (acc_w)
      for (int b = 0; b < 4; b++)
        if (be[b])
          bus_mem[a[7:2]][8*b +: 8] = wd[8*b +: 8];
    readdata = acc_r ? bus_mem[a[7:2]] : $urandom;
    w_last = acc_w;
    r_hist = {r_hist[0], acc_r};
    new_cmd = (read || write) && !prev_strobe;
    if (read || write) begin
      if (new_cmd)
        wait_left = wait_rand ?
          int'($urandom_range(0, 3)) : wait_fixed;
      waitrequest = (wait_left != 0);
      if (wait_left != 0) wait_left--;
    end else begin
      waitrequest = 1'($urandom_range(0, 1));
    end
    prev_strobe = read || write;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    f_req = 1'b0; d_req = 1'b0;
    cyc(); cyc();
    reset = 1'b0;
  endtask

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] mem_init;
    int          waits;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_word;
    int          exp_lat;
  } vec_t;

  vec_t tbl [6];

  // Random-phase model state.
  int          m_cnt, age;
  bit          busy, grant_pred, e_f, e_we, abort;
  logic [31:0] e_addr, e_wdata, last_f, last_d;
  logic [3:0]  e_be;

  initial begin
    active = 1'b1; reset = 1'b1;
    f_req = 0; f_addr = 0; d_req = 0; d_we = 0;
    d_addr = 0; d_byte_en = 0; d_wdata = 0;
    waitrequest = 0; readdata = 0;
    wait_rand = 0; wait_fixed = 0; wait_left = 0;
    prev_strobe = 0; w_last = 0; r_hist = 0;
    for (int i = 0; i < 64; i++) begin
      bus_mem[i] = $urandom;
      ref_mem[i] = bus_mem[i];
    end

    tbl[0] = '{0, 0, 32'h0000_000E, 4'h0, 32'h0,
      32'h2402_0005, 0, 32'h0000_000C, 4'hF,
      32'h2402_0005, 3};
    tbl[1] = '{1, 1, 32'h0000_0100, 4'b0011,
      32'hDEAD_BEEF, 32'h1122_3344, 3,
      32'h0000_0100, 4'b0011, 32'h1122_BEEF, 5};
    tbl[2] = '{1, 0, 32'h0000_0203, 4'hC, 32'h0,
      32'hCAFE_F00D, 1, 32'h0000_0200, 4'hC,
      32'hCAFE_F00D, 4};
    tbl[3] = '{0, 0, 32'hFFFF_FFFF, 4'h0, 32'h0,
      32'h0BAD_F00D, 2, 32'hFFFF_FFFC, 4'hF,
      32'h0BAD_F00D, 5};
    tbl[4] = '{1, 1, 32'h0000_0047, 4'hF,
      32'h0123_4567, 32'h0, 0, 32'h0000_0044,
      4'hF, 32'h0123_4567, 2};
    tbl[5] = '{1, 1, 32'h0000_01F0, 4'h0,
      32'hFFFF_FFFF, 32'h5A5A_5A5A, 1,
      32'h0000_01F0, 4'h0, 32'h5A5A_5A5A, 3};

    do_reset();
    chk("rst_address", address, 0);
    chk("rst_strobes",
        {read, write, f_ack, d_ack, byteenable}, 0);
    chk("rst_wdata", writedata, 0);
    chk("rst_f_rdata", f_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);

    // Isolated transactions from the table.
    foreach (tbl[i]) begin
      vec_t v;
      int held, lat;
      bit got, bad_stall, ak, st;
      v = tbl[i];
      bus_mem[v.exp_addr[7:2]] = v.mem_init;
      wait_fixed = v.waits;
      if (v.is_d) begin
        d_req = 1; d_we = v.we; d_addr = v.addr;
        d_byte_en = v.be; d_wdata = v.wdata;
      end else begin
        f_req = 1; f_addr = v.addr;
      end
      held = 0; lat = 0; got = 0; bad_stall = 0;
      for (int c = 1; c <= 20 && !got; c++) begin
        cyc();
        if (read || write) begin
          held++;
          if (held == 1) begin
            chk("tbl_addr", address, v.exp_addr);
            chk("tbl_be", byteenable, v.exp_be);
            chk("tbl_rw", {read, write},
                {!v.we, v.we});
            if (v.we)
              chk("tbl_wdata", writedata, v.wdata);
          end
        end
        ak = v.is_d ? d_ack : f_ack;
        st = v.is_d ? d_stall : f_stall;
        if (st == ak) bad_stall = 1;
        if (ak) begin got = 1; lat = c; end
      end
      f_req = 0; d_req = 0;
      chk("tbl_got_ack", got, 1);
      chk("tbl_held", held, v.waits + 1);
      chk("tbl_latency", lat, v.exp_lat);
      chk("tbl_stall", bad_stall, 0);
      if (v.we)
        chk("tbl_mem", bus_mem[v.exp_addr[7:2]],
            v.exp_word);
      else if (v.is_d)
        chk("tbl_d_rdata", d_rdata, v.exp_word);
      else
        chk("tbl_f_rdata", f_rdata, v.exp_word);
      cyc();
    end

    // Simultaneous requests: data first.
    begin
      int tda, tfa;
      logic [31:0] first_a;
      bit seen;
      wait_fixed = 0;
      bus_mem[0] = 32'hA5A5_0001;
      bus_mem[16] = 32'h5A5A_0002;
      f_req = 1; f_addr = 32'h40;
      d_req = 1; d_we = 0; d_addr = 32'h200;
      d_byte_en = 4'hF;
      tda = -1; tfa = -1; seen = 0; first_a = 0;
      for (int c = 1; c <= 20 && tfa < 0; c++) begin
        cyc();
        if (new_cmd && !seen) begin
          seen = 1; first_a = address;
        end
        if (d_ack) begin tda = c; d_req = 0; end
        if (f_ack) begin tfa = c; f_req = 0; end
      end
      f_req = 0; d_req = 0;
      chk("sim_first_grant", first_a, 32'h200);
      chk("sim_d_ack_cycle", tda, 3);
      chk("sim_f_after_d", tfa - tda, 3);
      chk("sim_d_rdata", d_rdata, 32'hA5A5_0001);
      chk("sim_f_rdata", f_rdata, 32'h5A5A_0002);
      cyc();
    end

    // Starvation: both held, fetch every 5th grant.
    begin
      bit [9:0] got_d, exp_d;
      int n;
      n = 0; got_d = 0;
      for (int k = 0; k < 10; k++)
        exp_d[k] = (k % 5 != 4);
      f_req = 1; f_addr = 32'h80;
      d_req = 1; d_we = 0; d_addr = 32'h300;
      for (int c = 0; c < 80 && n < 10; c++) begin
        cyc();
        if (new_cmd) begin
          got_d[n] = (address == 32'h300);
          n++;
        end
      end
      f_req = 0; d_req = 0;
      chk("starve_grants", n, 10);
      chk("starve_pattern", got_d, exp_d);
      for (int c = 0; c < 5; c++) cyc();
    end

    // Reset while a command is held on the bus.
    begin
      int acks, lat;
      wait_fixed = 10;
      f_req = 1; f_addr = 32'h10;
      cyc(); cyc();
      chk("rstmid_cmd", read, 1);
      reset = 1; f_req = 0;
      cyc();
      reset = 0;
      chk("rstmid_strobes", {read, write}, 0);
      acks = 0;
      for (int c = 0; c < 5; c++) begin
        cyc();
        acks += int'(f_ack) + int'(d_ack);
      end
      chk("rstmid_no_ack", acks, 0);
      wait_fixed = 0;
      bus_mem[5] = 32'h7777_1234;
      f_req = 1; f_addr = 32'h14;
      lat = 0;
      for (int c = 1; c <= 20 && lat == 0; c++) begin
        cyc();
        if (f_ack) lat = c;
      end
      f_req = 0;
      chk("rstmid_fresh_lat", lat, 3);
      chk("rstmid_fresh_data", f_rdata,
          32'h7777_1234);
      cyc();
    end

    // active low blocks grants; resumes next cycle.
    begin
      int strobes;
      active = 0;
      f_req = 1; f_addr = 32'h20;
      d_req = 1; d_we = 0; d_addr = 32'h240;
      strobes = 0;
      for (int c = 0; c < 5; c++) begin
        cyc();
        strobes += int'(read) + int'(write);
      end
      chk("inact_no_strobe", strobes, 0);
      chk("inact_stalls", {f_stall, d_stall}, 2'b11);
      active = 1;
      cyc();
      chk("inact_resume",
          {read, address}, {1'b1, 32'h240});
      f_req = 0; d_req = 0;
      for (int c = 0; c < 6; c++) cyc();
    end

    // Random traffic against reference model.
    for (int i = 0; i < 64; i++)
      ref_mem[i] = bus_mem[i];
    wait_rand = 1;
    do_reset();
    active = 1;
    m_cnt = 0; busy = 0; grant_pred = 0;
    abort = 0; age = 0; e_f = 0; e_we = 0;
    e_addr = 0; e_wdata = 0; e_be = 0;
    last_f = 0; last_d = 0;
    for (int n = 0; n < 3000 && !abort; n++) begin
      bit exp_ack;
      if (grant_pred) begin
        chk("rnd_grant", new_cmd, 1);
        chk("rnd_addr", address, e_addr);
        chk("rnd_rw", {read, write}, {!e_we, e_we});
        chk("rnd_be", byteenable, e_be);
        if (e_we) chk("rnd_wdata", writedata, e_wdata);
        grant_pred = 0; busy = 1; age = 0;
      end else begin
        chk("rnd_no_grant", new_cmd, 0);
      end
      exp_ack = busy && (w_last || r_hist[1]);
      chk("rnd_f_ack", f_ack, exp_ack && e_f);
      chk("rnd_d_ack", d_ack, exp_ack && !e_f);
      if (exp_ack) begin
        if (e_f) begin
          last_f = ref_mem[e_addr[7:2]];
          if ($urandom_range(0, 1) == 1) begin
            f_addr = $urandom;
          end else begin
            f_req = 0;
          end
        end else begin
          if (e_we) begin
            for (int b = 0; b < 4; b++)
              if (e_be[b])
                ref_mem[e_addr[7:2]][8*b +: 8] =
                  e_wdata[8*b +: 8];
            chk("rnd_mem", bus_mem[e_addr[7:2]],
                ref_mem[e_addr[7:2]]);
          end else begin
            last_d = ref_mem[e_addr[7:2]];
          end
          if ($urandom_range(0, 1) == 1) begin
            d_we = 1'($urandom_range(0, 1));
            d_addr = $urandom;
            d_byte_en = 4'($urandom);
            d_wdata = $urandom;
          end else begin
            d_req = 0;
          end
        end
        busy = 0;
      end
      chk("rnd_f_rdata", f_rdata, last_f);
      chk("rnd_d_rdata", d_rdata, last_d);
      if (busy) begin
        age++;
        if (age > 40) begin
          chk("rnd_timeout", age, 0);
          abort = 1;
        end
      end
      if (!f_req && $urandom_range(0, 2) == 0) begin
        f_req = 1; f_addr = $urandom;
      end
      if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req = 1;
        d_we = 1'($urandom_range(0, 1));
        d_addr = $urandom;
        d_byte_en = 4'($urandom);
        d_wdata = $urandom;
      end
      active = ($urandom_range(0, 7) != 0);
      if (!busy) begin
        if (!f_req) m_cnt = 0;
        if (active && (f_req || d_req)) begin
          e_f = f_req && (!d_req || m_cnt == LIMIT);
          if (e_f) begin
            m_cnt = 0;
            e_we = 0;
            e_addr = {f_addr[31:2], 2'b00};
            e_be = 4'hF;
          end else begin
            if (f_req && m_cnt < LIMIT) m_cnt++;
            e_we = d_we;
            e_addr = {d_addr[31:2], 2'b00};
            e_be = d_byte_en;
            e_wdata = d_wdata;
          end
          grant_pred = 1;
        end
      end
      #1;
      chk("rnd_f_stall", f_stall, f_req && !f_ack);
      chk("rnd_d_stall", d_stall, d_req && !d_ack);
      cyc();
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
